// File: rtl/mem_lsu_pkg.sv
// ============================================================================
// Module : mem_lsu_pkg
// Brief  : Shared bus widths, op encodings and memory-op decode helpers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_lsu_pkg;

  localparam int          C_REG_BUS      = 32;
  localparam int          C_REG_ADDR_BUS = 5;
  localparam logic [31:0] C_ZERO_WORD    = 32'h0000_0000;

  localparam logic [7:0] C_OP_LB  = 8'b1110_0000;
  localparam logic [7:0] C_OP_LBU = 8'b1110_0100;
  localparam logic [7:0] C_OP_LH  = 8'b1110_0001;
  localparam logic [7:0] C_OP_LHU = 8'b1110_0101;
  localparam logic [7:0] C_OP_LW  = 8'b1110_0011;
  localparam logic [7:0] C_OP_SB  = 8'b1110_1000;
  localparam logic [7:0] C_OP_SH  = 8'b1110_1001;
  localparam logic [7:0] C_OP_SW  = 8'b1110_1011;

  function automatic logic f_is_mem(input logic [7:0] op);
    case (op)
      C_OP_LB, C_OP_LBU, C_OP_LH, C_OP_LHU, C_OP_LW,
      C_OP_SB, C_OP_SH, C_OP_SW: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  // Bytes are always aligned; non-memory ops report aligned as well.
  function automatic logic f_aligned(input logic [7:0] op, input logic [1:0] addr_lo);
    case (op)
      C_OP_LH, C_OP_LHU, C_OP_SH: return ~addr_lo[0];
      C_OP_LW, C_OP_SW:           return (addr_lo == 2'b00);
      default:                    return 1'b1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane.sv
// ============================================================================
// Module : mem_lane
// Brief  : Big-endian byte-lane select, store replicate and load extract.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_lane
  import mem_lsu_pkg::*;
(
  input  logic [7:0]  i_aluop,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_reg2,
  input  logic [31:0] i_rdata,
  output logic        o_we,
  output logic [3:0]  o_sel,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_sel_byte;
  logic [3:0]  w_sel_half;

  // Lane 00 is the most significant byte.
  always_comb begin
    case (i_addr_lo)
      2'b00:   w_byte = i_rdata[31:24];
      2'b01:   w_byte = i_rdata[23:16];
      2'b10:   w_byte = i_rdata[15:8];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  assign w_half     = i_addr_lo[1] ? i_rdata[15:0] : i_rdata[31:16];
  assign w_sel_byte = 4'b1000 >> i_addr_lo;
  assign w_sel_half = i_addr_lo[1] ? 4'b0011 : 4'b1100;

  always_comb begin
    o_we    = 1'b0;
    o_sel   = 4'b0000;
    o_wdata = C_ZERO_WORD;
    o_load  = C_ZERO_WORD;
    case (i_aluop)
      C_OP_LB:  begin o_sel = w_sel_byte; o_load = {{24{w_byte[7]}}, w_byte}; end
      C_OP_LBU: begin o_sel = w_sel_byte; o_load = {24'h0, w_byte}; end
      C_OP_LH:  begin o_sel = w_sel_half; o_load = {{16{w_half[15]}}, w_half}; end
      C_OP_LHU: begin o_sel = w_sel_half; o_load = {16'h0, w_half}; end
      C_OP_LW:  begin o_sel = 4'b1111;    o_load = i_rdata; end
      C_OP_SB:  begin o_we = 1'b1; o_sel = w_sel_byte; o_wdata = {4{i_reg2[7:0]}}; end
      C_OP_SH:  begin o_we = 1'b1; o_sel = w_sel_half; o_wdata = {2{i_reg2[15:0]}}; end
      C_OP_SW:  begin o_we = 1'b1; o_sel = 4'b1111;    o_wdata = i_reg2; end
      default:  ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_lsu.sv
// ============================================================================
// Module : mem_lsu
// Brief  : MEM-stage load/store unit with a stalling data-bus handshake.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [C_REG_ADDR_BUS-1:0] ex_wd_i,
  input  logic                      ex_wreg_i,
  input  logic [C_REG_BUS-1:0]      ex_wdata_i,
  input  logic [7:0]                ex_aluop_i,
  input  logic [C_REG_BUS-1:0]      ex_reg2_i,
  input  logic                      stall_i,
  output logic                      stallreq_o,
  output logic [C_REG_ADDR_BUS-1:0] wb_wd_o,
  output logic                      wb_wreg_o,
  output logic [C_REG_BUS-1:0]      wb_wdata_o,
  output logic                      misalign_o,
  output logic                      bus_req_o,
  output logic                      bus_we_o,
  output logic [C_REG_BUS-1:0]      bus_addr_o,
  output logic [3:0]                bus_sel_o,
  output logic [C_REG_BUS-1:0]      bus_wdata_o,
  input  logic                      bus_ack_i,
  input  logic [C_REG_BUS-1:0]      bus_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                      r_state;
  state_e                      w_state_nxt;
  logic [7:0]                  r_op;
  logic [C_REG_BUS-1:0]        r_addr;
  logic [C_REG_BUS-1:0]        r_reg2;
  logic [C_REG_ADDR_BUS-1:0]   r_wd;
  logic                        r_wreg;
  logic                        r_buf_wreg;
  logic [C_REG_BUS-1:0]        r_buf_wdata;

  logic                        w_ex_mem;
  logic                        w_ex_aligned;
  logic                        w_busy;
  logic                        w_lane_we;
  logic [3:0]                  w_lane_sel;
  logic [C_REG_BUS-1:0]        w_lane_wdata;
  logic [C_REG_BUS-1:0]        w_lane_load;
  logic                        w_res_wreg;
  logic [C_REG_BUS-1:0]        w_res_wdata;

  assign w_ex_mem     = f_is_mem(ex_aluop_i);
  assign w_ex_aligned = f_aligned(ex_aluop_i, ex_wdata_i[1:0]);
  assign w_busy       = (r_state == S_BUSY);

  mem_lane u_lane (
    .i_aluop   (r_op),
    .i_addr_lo (r_addr[1:0]),
    .i_reg2    (r_reg2),
    .i_rdata   (bus_rdata_i),
    .o_we      (w_lane_we),
    .o_sel     (w_lane_sel),
    .o_wdata   (w_lane_wdata),
    .o_load    (w_lane_load)
  );

  // Stores complete as a write-back bubble.
  assign w_res_wreg  = r_wreg & ~w_lane_we;
  assign w_res_wdata = w_lane_we ? C_ZERO_WORD : w_lane_load;

  // Bus fields come from latched state, so they stay stable through BUSY.
  assign bus_req_o   = w_busy;
  assign bus_we_o    = w_busy & w_lane_we;
  assign bus_addr_o  = w_busy ? {r_addr[C_REG_BUS-1:2], 2'b00} : C_ZERO_WORD;
  assign bus_sel_o   = w_busy ? w_lane_sel : 4'b0000;
  assign bus_wdata_o = w_busy ? w_lane_wdata : C_ZERO_WORD;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    stallreq_o  = 1'b0;
    case (r_state)
      S_IDLE: begin
        stallreq_o = w_ex_mem & w_ex_aligned;
        if (!stall_i && w_ex_mem && w_ex_aligned) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        stallreq_o = ~bus_ack_i;
        if (bus_ack_i) w_state_nxt = stall_i ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        if (!stall_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_wd_o     <= '0;
      wb_wreg_o   <= 1'b0;
      wb_wdata_o  <= C_ZERO_WORD;
      misalign_o  <= 1'b0;
      r_op        <= 8'h00;
      r_addr      <= C_ZERO_WORD;
      r_reg2      <= C_ZERO_WORD;
      r_wd        <= '0;
      r_wreg      <= 1'b0;
      r_buf_wreg  <= 1'b0;
      r_buf_wdata <= C_ZERO_WORD;
    end else begin
      misalign_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!stall_i) begin
            if (!w_ex_mem) begin
              wb_wd_o    <= ex_wd_i;
              wb_wreg_o  <= ex_wreg_i;
              wb_wdata_o <= ex_wdata_i;
            end else begin
              wb_wd_o    <= ex_wd_i;
              wb_wreg_o  <= 1'b0;
              wb_wdata_o <= C_ZERO_WORD;
              if (w_ex_aligned) begin
                r_op   <= ex_aluop_i;
                r_addr <= ex_wdata_i;
                r_reg2 <= ex_reg2_i;
                r_wd   <= ex_wd_i;
                r_wreg <= ex_wreg_i;
              end else begin
                misalign_o <= 1'b1;
              end
            end
          end
        end
        S_BUSY: begin
          if (bus_ack_i) begin
            if (!stall_i) begin
              wb_wd_o    <= r_wd;
              wb_wreg_o  <= w_res_wreg;
              wb_wdata_o <= w_res_wdata;
            end else begin
              r_buf_wreg  <= w_res_wreg;
              r_buf_wdata <= w_res_wdata;
            end
          end
        end
        S_DONE: begin
          if (!stall_i) begin
            wb_wd_o    <= r_wd;
            wb_wreg_o  <= r_buf_wreg;
            wb_wdata_o <= r_buf_wdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Reset rst, synchronous, active-high.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 ex_wd_i  in  5  destination register address from EX.
REQ-005 ex_wreg_i  in  1  write-enable from EX.
REQ-006 ex_wdata_i  in  32  EX result; the address for load/store ops.
REQ-007 ex_aluop_i  in  8  operation code from EX (shared op encodings).
REQ-008 ex_reg2_i  in  32  store data (rt value).
REQ-009 stall_i  in  1  pipeline-control hold for this stage.
REQ-010 stallreq_o  out  1  request to pipeline control to hold EX and upstream.
REQ-011 wb_wd_o  out  5, wb_wreg_o  out  1, wb_wdata_o  out  32  registered write-back result.
REQ-012 misalign_o  out  1  one-cycle pulse on a misaligned access.
REQ-013 bus_req_o  out  1, bus_we_o  out  1, bus_addr_o  out  32 (bits 1:0 forced 0), bus_sel_o  out  4, bus_wdata_o  out  32  data-bus request.
REQ-014 bus_ack_i  in  1, bus_rdata_i  in  32  data-bus completion and read data.

Function
REQ-015 Memory ops SHALL be LB, LBU, LH, LHU, LW, SB, SH and SW; every other op is pass-through.
REQ-016 FSM states SHALL be IDLE, BUSY and DONE.
REQ-017 In IDLE with stall_i=0 and a pass-through op, the SHALL register wb_* <= ex_wd_i, ex_wreg_i and ex_wdata_i (1-cycle latency).
REQ-018 In IDLE with stall_i=0 and an aligned memory op, the block SHALL latch the op, address, store data and wd, set wb_wreg_o=0 (bubble) and go to BUSY.
REQ-019 Alignment SHALL be: halfword needs addr[0]=0; word needs addr[1:0]=00; byte is always aligned.
REQ-020 A misaligned memory op SHALL issue no bus request, SHALL pulse misalign_o for 1 cycle, SHALL write a bubble (wb_wreg_o=0) and SHALL remain in IDLE.
REQ-021 stallreq_o SHALL be combinational: 1 when (IDLE and an aligned memory op is on the inputs) or (BUSY and bus_ack_i=0); otherwise 0.
REQ-022 bus_req_o SHALL be 1 exactly while in BUSY; bus_addr_o, bus_we_o, bus_sel_o and bus_wdata_o SHALL be stable throughout BUSY.
REQ-023 Byte lanes SHALL be big-endian: byte at addr[1:0]=00 maps to bits 31:24 with sel 1000, 01 maps to 23:16 with sel 0100, and so on; halfword at 00 uses sel 1100, at 10 uses sel 0011; word uses sel 1111.
REQ-024 Stores SHALL replicate the rt byte or halfword across all lanes on bus_wdata_o.
REQ-025 Loads SHALL extract the selected lane; LB and LH sign-extend, LBU and LHU zero-extend.
REQ-026 On bus_ack_i in BUSY with stall_i=0, the block SHALL write the load result (wreg=latched value) or a store bubble (wreg=0) to wb_* and go to IDLE.
REQ-027 On bus_ack_i in BUSY with stall_i=1, the block SHALL buffer the result and go to DONE.
REQ-028 DONE SHALL hold stallreq_o=0; on stall_i=0 it SHALL drive the buffered result to wb_* and go to IDLE.
REQ-029 In IDLE with stall_i=1, wb_* SHALL hold its values and no new op is accepted.
REQ-030 bus_ack_i outside BUSY SHALL be ignored.
REQ-031 Minimum memory-op latency SHALL be 2 cycles (accept edge to ack edge).

Reset
REQ-032 rst SHALL force IDLE, wb_wd_o=0, wb_wreg_o=0, wb_wdata_o=0, misalign_o=0, and all bus_* outputs to 0, including mid-BUSY or mid-DONE; a pending transaction is abandoned.

Structure
REQ-033 Memory op codes and the ZeroWord, RegBus and RegAddrBus widths SHALL live in the shared defines file.
REQ-034 State encodings SHALL be local to the module.
REQ-035 Lane select, load extract and store replicate logic SHALL form one combinational sub-module, mem_lane.

Verification
REQ-036 OR op, wd=5, data=0x0000_00F0 -> next cycle wb_wreg_o=1, wb_wd_o=5, wb_wdata_o=0x0000_00F0, stallreq_o=0.
REQ-037 LB addr=0x1001, rdata=0x1280_3456, ack after 3 BUSY cycles -> sel=0100, wb_wdata_o=0xFFFF_FF80; stallreq_o high until the ack cycle.
REQ-038 SH addr=0x2002, rt=0xAAAA_BEEF -> bus_we_o=1, sel=0011, wdata=0xBEEF_BEEF, wb_wreg_o=0.
REQ-039 LW addr=0x3 -> misalign_o pulse, bus_req_o stays 0, wb_wreg_o=0.
REQ-040 LHU ack arriving while stall_i=1 -> DONE; result 0x0000_8001 appears on wb_* only after stall_i falls.
REQ-041 rst asserted mid-BUSY -> next cycle IDLE, bus_req_o=0, all outputs 0; a later ack has no effect.
